msg_block_packer: RTL

- Upstream feeder for the Romulus-N cipher datapath. Packs a W-bit word stream of message bytes into BLK_SIZE-bit blocks and applies Romulus padding to the final partial block.
- Outputs blocks on the cipher's plaintext handshake: blk_data, blk_nbytes and blk_valid map to plaintext, plaintext_nbytes and plaintext_valid; blk_ready maps to plaintext_ready.
- blk_last drives the cipher's last-block indication.
- Guarantees the cipher contract: every non-last block has BLK_SIZE/8 bytes; the last block has 0..BLK_SIZE/8-1 bytes.

---
 rtl/romulus_pkg.sv | 16 +
 rtl/blk_pad.sv | 30 +++
 rtl/msg_block_packer.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/romulus_pkg.sv
// Shared constants and the packer state type for the Romulus-N message front end.
package romulus_pkg;

    localparam int DEF_BLK_SIZE  = 128;
    localparam int DEF_W         = 32;
    localparam int BLK_BYTES     = DEF_BLK_SIZE / 8;
    localparam int NB_W          = $clog2(BLK_BYTES) + 1;
    localparam int WORDS_PER_BLK = DEF_BLK_SIZE / DEF_W;

    typedef enum logic [1:0] {
        FILL     = 2'd0,
        EMIT     = 2'd1,
        EMIT_PAD = 2'd2
    } state_t;

endpackage

// File: rtl/blk_pad.sv
// Combinational Romulus block padder: keeps the first i_total message bytes,
// zeroes the rest and, on a short final block, writes the length into the last byte.
module blk_pad
    import romulus_pkg::*;
#(
    parameter int BLK_SIZE = DEF_BLK_SIZE,
    parameter int NB_W_P   = $clog2(BLK_SIZE / 8) + 1
) (
    input  logic [BLK_SIZE-1:0] i_raw,
    input  logic [NB_W_P-1:0]   i_total,
    input  logic                i_last,
    output logic [BLK_SIZE-1:0] o_blk
);

    localparam int BYTES = BLK_SIZE / 8;

    // Byte mask plus length byte; byte 0 sits in the most significant position.
    always_comb begin
        o_blk = '0;
        for (int k = 0; k < BYTES; k++) begin
            if (k < int'(i_total)) begin
                o_blk[BLK_SIZE-1-8*k -: 8] = i_raw[BLK_SIZE-1-8*k -: 8];
            end
        end
        if (i_last && (int'(i_total) < BYTES)) begin
            o_blk[7:0] = 8'(i_total);
        end
    end

endmodule

// File: rtl/msg_block_packer.sv
// Packs a W-bit message word stream into BLK_SIZE-bit blocks for the Romulus-N
// plaintext interface, adding the trailing empty padded block when a message
// ends exactly on a block boundary.
module msg_block_packer
    import romulus_pkg::*;
#(
    parameter int BLK_SIZE = DEF_BLK_SIZE,
    parameter int W        = DEF_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [W-1:0]                  in_data,
    input  logic [$clog2(W/8):0]          in_nbytes,
    input  logic                          in_last,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [BLK_SIZE-1:0]           blk_data,
    output logic [$clog2(BLK_SIZE/8):0]   blk_nbytes,
    output logic                          blk_last,
    output logic                          blk_valid,
    input  logic                          blk_ready
);

    localparam int BB    = BLK_SIZE / 8;
    localparam int NBW   = $clog2(BB) + 1;
    localparam int WPB   = BLK_SIZE / W;
    localparam int WB    = W / 8;
    localparam int CNT_W = (WPB > 1) ? $clog2(WPB) : 1;

    state_t              r_state;
    state_t              w_next;
    logic [CNT_W-1:0]    r_word_cnt;
    logic [BLK_SIZE-1:0] r_raw;
    logic [NBW-1:0]      r_nbytes;
    logic                r_last;
    logic                r_pad_pending;

    logic [W-1:0]        w_word;
    logic [NBW-1:0]      w_total;
    logic                w_accept;
    logic                w_cnt_full;

    assign in_ready   = (r_state == FILL);
    assign blk_valid  = (r_state != FILL);
    assign w_accept   = in_valid && (r_state == FILL);
    assign w_cnt_full = (r_word_cnt == CNT_W'(WPB - 1));
    assign w_total    = NBW'(int'(r_word_cnt) * WB + int'(in_nbytes));
    assign blk_nbytes = r_nbytes;
    assign blk_last   = r_last;

    // Drop bytes beyond in_nbytes so a short last word never leaks stale data.
    always_comb begin
        w_word = '0;
        for (int b = 0; b < WB; b++) begin
            if (b < int'(in_nbytes)) begin
                w_word[W-1-8*b -: 8] = in_data[W-1-8*b -: 8];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= FILL;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode: fill until a block completes, then hold it until consumed.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            FILL: begin
                if (in_valid && (in_last || w_cnt_full)) begin
                    w_next = EMIT;
                end
            end
            EMIT: begin
                if (blk_ready) begin
                    w_next = r_pad_pending ? EMIT_PAD : FILL;
                end
            end
            EMIT_PAD: begin
                if (blk_ready) begin
                    w_next = FILL;
                end
            end
            default: w_next = FILL;
        endcase
    end

    // Block assembly, word slot counter and the per-block length/last bookkeeping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_word_cnt    <= '0;
            r_raw         <= '0;
            r_nbytes      <= '0;
            r_last        <= 1'b0;
            r_pad_pending <= 1'b0;
        end else begin
            if (w_accept) begin
                r_raw[(WPB-1-int'(r_word_cnt))*W +: W] <= w_word;
                if (!in_last) begin
                    if (w_cnt_full) begin
                        r_word_cnt <= '0;
                        r_nbytes   <= NBW'(BB);
                        r_last     <= 1'b0;
                    end else begin
                        r_word_cnt <= r_word_cnt + CNT_W'(1);
                    end
                end else begin
                    r_word_cnt <= '0;
                    if (w_total < NBW'(BB)) begin
                        r_nbytes <= w_total;
                        r_last   <= 1'b1;
                    end else begin
                        r_nbytes      <= NBW'(BB);
                        r_last        <= 1'b0;
                        r_pad_pending <= 1'b1;
                    end
                end
            end else if ((r_state == EMIT) && blk_ready) begin
                r_raw      <= '0;
                r_nbytes   <= '0;
                r_word_cnt <= '0;
                r_last     <= r_pad_pending;
            end else if ((r_state == EMIT_PAD) && blk_ready) begin
                r_pad_pending <= 1'b0;
                r_last        <= 1'b0;
                r_nbytes      <= '0;
            end
        end
    end

    // Output block: raw contents masked to the byte count, with the length byte on a short last block.
    blk_pad #(
        .BLK_SIZE (BLK_SIZE),
        .NB_W_P   (NBW)
    ) u_blk_pad (
        .i_raw   (r_raw),
        .i_total (r_nbytes),
        .i_last  (r_last),
        .o_blk   (blk_data)
    );

endmodule
